// File: rtl/lsram_fifo_pkg.sv
// Shared constants and types for the LSRAM FIFO controller.
// DWIDTH/AWIDTH describe the 1024x40 two-port LSRAM macro the controller drives.
package lsram_fifo_pkg;

  localparam int DWIDTH = 40;
  localparam int AWIDTH = 10;
  localparam int DEPTH  = 2 ** AWIDTH;

  typedef logic [AWIDTH-1:0] addr_t;   // RAM address / pointer
  typedef logic [AWIDTH:0]   cnt_t;    // words held in the RAM, 0..DEPTH
  typedef logic [AWIDTH+1:0] level_t;  // total occupancy, 0..DEPTH+2
  typedef logic [DWIDTH-1:0] data_t;
  typedef logic [1:0]        stage_cnt_t;

endpackage

// File: rtl/lsram_fifo_outstage.sv
// Two-entry head/skid output stage with first-word-fall-through.
// Read data returning from the RAM is presented directly while the head is
// empty, so a word is visible the cycle after its read was issued; if it is
// not popped it is captured into the head (or the skid when the head is busy).
module lsram_fifo_outstage
  import lsram_fifo_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       flush,
  input  logic       inflight,
  input  data_t      ram_rdata,
  input  logic       pop,
  output logic       rd_valid,
  output data_t      rd_data,
  output stage_cnt_t stage_cnt
);

  logic  head_valid;
  logic  skid_valid;
  data_t head_data;
  data_t skid_data;

  // Head/skid update: capture returning data, advance skid into head on pop.
  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      head_valid <= 1'b0;
      skid_valid <= 1'b0;
      head_data  <= '0;
      skid_data  <= '0;
    end else if (head_valid) begin
      if (pop) begin
        if (skid_valid) begin
          head_data <= skid_data;
          if (inflight) begin
            skid_data <= ram_rdata;
          end else begin
            skid_valid <= 1'b0;
          end
        end else if (inflight) begin
          head_data <= ram_rdata;
        end else begin
          head_valid <= 1'b0;
        end
      end else if (inflight) begin
        skid_data  <= ram_rdata;
        skid_valid <= 1'b1;
      end
    end else if (inflight && !pop) begin
      head_data  <= ram_rdata;
      head_valid <= 1'b1;
    end
  end

  // Head word, or the RAM output directly when the head is empty.
  always_comb begin
    rd_valid = head_valid | inflight;
    if (!head_valid && inflight) begin
      rd_data = ram_rdata;
    end else begin
      rd_data = head_data;
    end
  end

  assign stage_cnt = stage_cnt_t'({1'b0, head_valid}) + stage_cnt_t'({1'b0, skid_valid});

endmodule

// File: rtl/lsram_fifo_ctrl.sv
// Synchronous FIFO controller for the 1024x40 two-port LSRAM macro.
// Owns pointers, RAM occupancy, total LEVEL and the AFULL/AEMPTY flags.
// Optional statistics (OVERFLOW, UNDERFLOW, MAX_LEVEL) are built only when
// the macro LSRAM_FIFO_CTRL_STATS_EN is defined; otherwise they read as 0.
module lsram_fifo_ctrl
  import lsram_fifo_pkg::*;
#(
  parameter int AFULL_TH  = 1000,
  parameter int AEMPTY_TH = 8
) (
  input  logic   CLK,
  input  logic   RESET_N,
  input  logic   FLUSH,
  input  data_t  WR_DATA,
  input  logic   WR_VALID,
  output logic   WR_READY,
  output data_t  RD_DATA,
  output logic   RD_VALID,
  input  logic   RD_READY,
  output level_t LEVEL,
  output logic   AFULL,
  output logic   AEMPTY,
  output data_t  RAM_W_DATA,
  output addr_t  RAM_W_ADDR,
  output logic   RAM_W_EN,
  output addr_t  RAM_R_ADDR,
  output logic   RAM_R_EN,
  input  data_t  RAM_R_DATA,
  output logic   OVERFLOW,
  output logic   UNDERFLOW,
  output level_t MAX_LEVEL,
  input  logic   STATS_CLR
);

  addr_t      wptr;
  addr_t      rptr;
  cnt_t       ram_cnt;
  logic       inflight;
  level_t     level;
  level_t     level_next;
  logic       afull;
  logic       aempty;
  logic       push;
  logic       pop;
  logic       issue;
  stage_cnt_t stage_cnt;

  // Space exists only for words not yet committed to the RAM.
  assign WR_READY = RESET_N & (ram_cnt < cnt_t'(DEPTH));

  // Handshakes, read issue and next-state occupancy.
  always_comb begin
    push  = WR_VALID & WR_READY & ~FLUSH;
    pop   = RD_VALID & RD_READY & ~FLUSH;
    // Issue only while the stage plus the read in flight, after this pop, leaves room.
    issue = RESET_N & ~FLUSH & (ram_cnt != cnt_t'(0)) &
            (({1'b0, stage_cnt} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));
    if (FLUSH) begin
      level_next = '0;
    end else begin
      level_next = level + level_t'(push) - level_t'(pop);
    end
  end

  // Pointers, committed RAM word count and the one-cycle read-in-flight marker.
  always_ff @(posedge CLK) begin
    if (!RESET_N || FLUSH) begin
      wptr     <= '0;
      rptr     <= '0;
      ram_cnt  <= '0;
      inflight <= 1'b0;
    end else begin
      if (push) begin
        wptr <= wptr + addr_t'(1);
      end
      if (issue) begin
        rptr <= rptr + addr_t'(1);
      end
      ram_cnt  <= ram_cnt + cnt_t'(push) - cnt_t'(issue);
      inflight <= issue;
    end
  end

  // Total level and flags, all registered from the same next-state value.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      level  <= '0;
      afull  <= 1'b0;
      aempty <= 1'b1;
    end else begin
      level  <= level_next;
      afull  <= (level_next >= level_t'(AFULL_TH));
      aempty <= (level_next <= level_t'(AEMPTY_TH));
    end
  end

  lsram_fifo_outstage u_outstage (
    .clk       (CLK),
    .reset_n   (RESET_N),
    .flush     (FLUSH),
    .inflight  (inflight),
    .ram_rdata (RAM_R_DATA),
    .pop       (pop),
    .rd_valid  (RD_VALID),
    .rd_data   (RD_DATA),
    .stage_cnt (stage_cnt)
  );

  assign LEVEL      = level;
  assign AFULL      = afull;
  assign AEMPTY     = aempty;
  assign RAM_W_DATA = WR_DATA;
  assign RAM_W_ADDR = wptr;
  assign RAM_W_EN   = push;
  assign RAM_R_ADDR = rptr;
  assign RAM_R_EN   = issue;

`ifdef LSRAM_FIFO_CTRL_STATS_EN
  logic   overflow;
  logic   underflow;
  level_t max_level;
  level_t max_base;

  // A clear drops the old high-water mark; the current level still counts.
  always_comb begin
    if (STATS_CLR) begin
      max_base = '0;
    end else begin
      max_base = max_level;
    end
  end

  // Sticky error flags and high-water mark; a new event beats a clear.
  always_ff @(posedge CLK) begin
    if (!RESET_N || FLUSH) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
      max_level <= '0;
    end else begin
      overflow  <= (WR_VALID & ~WR_READY) | (overflow & ~STATS_CLR);
      underflow <= (RD_READY & ~RD_VALID) | (underflow & ~STATS_CLR);
      max_level <= (level_next > max_base) ? level_next : max_base;
    end
  end

  assign OVERFLOW  = overflow;
  assign UNDERFLOW = underflow;
  assign MAX_LEVEL = max_level;
`else
  logic unused_stats_clr;
  assign unused_stats_clr = STATS_CLR;
  assign OVERFLOW  = 1'b0;
  assign UNDERFLOW = 1'b0;
  assign MAX_LEVEL = '0;
`endif

endmodule
